data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, byte-address width; storage is 2^(ADDR_WIDTH-1) 16-bit words.
REQ-002 SHALL have parameter LATENCY, default 4, cycles from request acceptance to first response word; legal range 1..15.
REQ-003 SHALL have parameter BURST_LEN, default 8, words returned per burst read; power of two, 2..8.
REQ-004 SHALL have port clk, input, 1, sole clock, all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 1, requester presents a request.
REQ-007 SHALL have port req_ready, output, 1, responder can accept a request this cycle.
REQ-008 SHALL have port req_wr, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have port req_burst, input, 1, 1 = burst read of BURST_LEN words; ignored when req_wr = 1.
REQ-010 SHALL have port req_addr, input, ADDR_WIDTH, byte address; bit 0 ignored.
REQ-011 SHALL have port req_wdata, input, 16, write data.
REQ-012 SHALL have port rsp_valid, output, 1, response word or write acknowledge valid.
REQ-013 SHALL have port rsp_rdata, output, 16, read data; 0 when rsp_valid = 0.
REQ-014 SHALL have port rsp_last, output, 1, final beat of the current response.

Function
REQ-015 SHALL implement states IDLE, WAIT, STREAM.
REQ-016 SHALL drive req_ready = 1 only in IDLE; a request is accepted on an edge where req_valid & req_ready = 1.
REQ-017 SHALL latch req_wr, req_burst, word address (req_addr[ADDR_WIDTH-1:1]) and req_wdata at acceptance; later input changes SHALL have no effect.
REQ-018 SHALL, at acceptance, move IDLE->WAIT and load a down-counter with LATENCY-1.
REQ-019 SHALL, in WAIT, decrement the counter each cycle; at counter 0, move to STREAM on the next edge.
REQ-020 SHALL, with acceptance on edge T, assert rsp_valid on the cycle after edge T+LATENCY-1, i.e. first beat exactly LATENCY cycles after acceptance.
REQ-021 SHALL, for single read, return one beat with rsp_last = 1, then return to IDLE.
REQ-022 SHALL, for write, commit req_wdata to storage on the edge ending the single ack beat (rsp_valid = 1, rsp_last = 1, rsp_rdata = 0), then return to IDLE.
REQ-023 SHALL, for burst read, align start to a BURST_LEN-word block (clear low log2(BURST_LEN) word-address bits), return BURST_LEN consecutive beats with no gaps in ascending word order, rsp_last = 1 only on the final beat.
REQ-024 SHALL keep burst addresses within the aligned block; no wrap past the top of memory is possible.
REQ-025 SHALL not support backpressure on the response side; the requester must sink every beat.
REQ-026 SHALL ignore req_valid in WAIT and STREAM (req_ready = 0), with no queuing.
REQ-027 SHALL, on the cycle after the last beat, present req_ready = 1 (one idle cycle minimum between responses is not required beyond this).
REQ-028 SHALL provide read data combinationally from storage indexed by the current beat address; reads in the same response as no pending write see the prior contents.

Reset
REQ-029 SHALL, while rst = 1 at an edge, force state IDLE, counter 0, beat index 0; outputs after that edge: req_ready = 1, rsp_valid = 0, rsp_last = 0, rsp_rdata = 0.
REQ-030 SHALL abort any in-flight request on reset; an aborted write SHALL NOT modify storage.
REQ-031 SHALL not clear storage contents on reset.

Structure
REQ-032 SHALL place the state enum (IDLE, WAIT, STREAM) and default LATENCY/BURST_LEN constants in shared package mem_pkg.
REQ-033 SHALL instantiate one sub-module mem_resp_array: single-port 16-bit word storage, synchronous write, combinational read.

Verification
REQ-034 SHALL cover write 0x1234 to byte addr 0x0010, then single read of 0x0010 -> write ack at acceptance+4 with rsp_last = 1; read beat at acceptance+4 returns 0x1234.
REQ-035 SHALL cover burst read at byte addr 0x0026 (LATENCY 4, BURST_LEN 8) -> 8 consecutive beats for word addrs 0x10..0x17, rsp_last only on the 8th, req_ready low throughout.
REQ-036 SHALL cover req_valid held high during WAIT with different addr -> ignored; only the first request responds; next request accepted the cycle after rsp_last.
REQ-037 SHALL cover write 0xBEEF to 0x0040 with rst asserted 2 cycles after acceptance -> no rsp_valid, IDLE next cycle, later read of 0x0040 returns the pre-write value.
REQ-038 SHALL cover LATENCY = 1 single read -> rsp_valid on the cycle immediately following acceptance; req_ready = 1 the cycle after that.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder.
//   state_e           : responder FSM states (IDLE, WAIT, STREAM)
//   DEFAULT_LATENCY   : default request-to-first-beat latency in cycles
//   DEFAULT_BURST_LEN : default number of words in a burst read
//   DATA_W            : storage word width in bits
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        STREAM = 2'd2
    } state_e;

    localparam int DEFAULT_LATENCY   = 4;
    localparam int DEFAULT_BURST_LEN = 8;
    localparam int DATA_W            = 16;

endpackage

// File: rtl/mem_resp_array.sv
// Single-port word storage for the responder.
//   clk   : clock, write on rising edge
//   we    : write enable
//   addr  : word address shared by read and write
//   wdata : write data
//   rdata : combinational read data at addr
// Contents are never cleared; there is deliberately no reset.
module mem_resp_array
    import mem_pkg::*;
#(
    parameter int AW = 15
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [0:(2**AW)-1];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency memory responder: accepts one request at a time, and after
// LATENCY cycles returns a single read beat, a write acknowledge, or a
// BURST_LEN-beat aligned burst read. No response backpressure.
//   clk, rst                : clock and synchronous active-high reset
//   req_valid / req_ready   : request handshake (ready only while idle)
//   req_wr, req_burst       : request type (burst ignored for writes)
//   req_addr, req_wdata     : byte address (bit 0 ignored) and write data
//   rsp_valid, rsp_rdata    : response beat and its read data (0 otherwise)
//   rsp_last                : final beat of the current response
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = DEFAULT_LATENCY,
    parameter int BURST_LEN  = DEFAULT_BURST_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic                  req_burst,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_last
);

    localparam int WAW = ADDR_WIDTH - 1;
    localparam int BLW = $clog2(BURST_LEN);
    localparam int CW  = 4;

    state_e            state_r;
    logic [CW-1:0]     cnt_r;
    logic [BLW-1:0]    beat_r;
    logic [WAW-1:0]    base_r;
    logic              wr_r;
    logic              burst_r;
    logic [DATA_W-1:0] wdata_r;
    logic              ready_r;
    logic              valid_r;
    logic              last_r;

    logic [WAW-1:0]    beat_addr_s;
    logic [DATA_W-1:0] rdata_s;
    logic              we_s;
    logic              req_burst_s;
    logic [WAW-1:0]    req_base_s;
    logic              unused_s;

    assign unused_s    = req_addr[0];
    assign req_burst_s = req_burst & ~req_wr;

    // Start word of the response: block-aligned for bursts, exact otherwise
    always_comb begin
        req_base_s = req_addr[ADDR_WIDTH-1:1];
        if (req_burst_s) begin
            req_base_s[BLW-1:0] = '0;
        end else begin
            req_base_s = req_addr[ADDR_WIDTH-1:1];
        end
    end

    // Base is aligned for bursts, so OR-ing the beat index stays in the block
    assign beat_addr_s = base_r | {{(WAW-BLW){1'b0}}, beat_r};

    // The only write beat is the ack, which is also the last beat
    assign we_s = valid_r & wr_r & ~rst;

    mem_resp_array #(.AW(WAW)) u_array (
        .clk   (clk),
        .we    (we_s),
        .addr  (beat_addr_s),
        .wdata (wdata_r),
        .rdata (rdata_s)
    );

    // Response data is driven only on read beats
    always_comb begin
        if (valid_r && !wr_r) begin
            rsp_rdata = rdata_s;
        end else begin
            rsp_rdata = {DATA_W{1'b0}};
        end
    end

    assign req_ready = ready_r;
    assign rsp_valid = valid_r;
    assign rsp_last  = last_r;

    // Request/response FSM with registered handshake and beat flags.
    // cnt_r holds the cycles remaining before the first beat; STREAM is
    // entered on the edge where it would reach 0, so the first beat appears
    // exactly LATENCY cycles after acceptance (LATENCY = 1 skips WAIT).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            beat_r  <= '0;
            base_r  <= '0;
            wr_r    <= 1'b0;
            burst_r <= 1'b0;
            wdata_r <= '0;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        wr_r    <= req_wr;
                        burst_r <= req_burst_s;
                        base_r  <= req_base_s;
                        wdata_r <= req_wdata;
                        beat_r  <= '0;
                        ready_r <= 1'b0;
                        if (LATENCY == 1) begin
                            state_r <= STREAM;
                            cnt_r   <= '0;
                            valid_r <= 1'b1;
                            last_r  <= ~req_burst_s;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= CW'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_r == CW'(1)) begin
                        state_r <= STREAM;
                        cnt_r   <= '0;
                        valid_r <= 1'b1;
                        last_r  <= ~burst_r;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                STREAM: begin
                    if (last_r) begin
                        state_r <= IDLE;
                        beat_r  <= '0;
                        ready_r <= 1'b1;
                        valid_r <= 1'b0;
                        last_r  <= 1'b0;
                    end else begin
                        beat_r <= beat_r + BLW'(1);
                        last_r <= (beat_r == BLW'(BURST_LEN - 2));
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    beat_r  <= '0;
                    ready_r <= 1'b1;
                    valid_r <= 1'b0;
                    last_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: a default instance (LATENCY 4,
// BURST_LEN 8) and a LATENCY 1 / BURST_LEN 2 instance, checked against a
// word-array reference model of memory and the response timing rules.
module tb_data_mem_responder;

    localparam int L  = 4;
    localparam int N  = 8;

    logic        clk = 1'b0;
    logic        rst;

    logic        req_valid, req_ready, req_wr, req_burst;
    logic [15:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_last;
    logic [15:0] rsp_rdata;

    logic        b_req_valid, b_req_ready, b_req_wr, b_req_burst;
    logic [7:0]  b_req_addr;
    logic [15:0] b_req_wdata;
    logic        b_rsp_valid, b_rsp_last;
    logic [15:0] b_rsp_rdata;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    // Reference memory for word addresses 0..63 of the default instance
    logic [15:0] model [0:63];

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_WIDTH(16), .LATENCY(L), .BURST_LEN(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_burst(req_burst), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last)
    );

    data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(1), .BURST_LEN(2)) dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wr(b_req_wr),
        .req_burst(b_req_burst), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_last(b_rsp_last)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request to the default instance and check every cycle of
    // its response; inputs are scrambled with req_valid high while busy.
    task automatic run_txn(input bit wr, input bit burst, input logic [15:0] addr,
                           input logic [15:0] wdata);
        int n, guard, wa, idx;
        logic [15:0] exp_d;
        bit exp_v, exp_l, exp_r;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 40) begin
            step();
            guard++;
        end
        vec_cnt++;
        if (req_ready !== 1'b1) begin
            miss_cnt++;
            $display("FAIL ready_wait: req_ready=%b, want 1", req_ready);
        end
        req_valid = 1'b1; req_wr = wr; req_burst = burst;
        req_addr = addr; req_wdata = wdata;
        step();
        n  = wr ? 1 : (burst ? N : 1);
        wa = int'(addr[15:1]);
        for (int k = 1; k <= L + n; k++) begin
            if (k < L + n) begin
                req_valid = 1'b1;
                req_wr    = 1'($urandom);
                req_burst = 1'($urandom);
                req_addr  = 16'($urandom);
                req_wdata = 16'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            exp_v = (k >= L) && (k < L + n);
            exp_l = (k == L + n - 1);
            exp_r = (k == L + n);
            idx   = (burst && !wr) ? ((wa / N) * N + (k - L)) : wa;
            exp_d = (exp_v && !wr) ? model[idx] : 16'h0000;
            vec_cnt++;
            if ({rsp_valid, rsp_last, req_ready, rsp_rdata} !== {exp_v, exp_l, exp_r, exp_d}) begin
                miss_cnt++;
                $display("FAIL txn wr=%0d burst=%0d addr=%h cyc=%0d: got v=%b l=%b rdy=%b d=%h, want v=%b l=%b rdy=%b d=%h",
                         wr, burst, addr, k, rsp_valid, rsp_last, req_ready, rsp_rdata,
                         exp_v, exp_l, exp_r, exp_d);
            end
            if (k < L + n) step();
        end
        if (wr) model[wa] = wdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_burst = 1'b0;
        req_addr = 16'h0000; req_wdata = 16'h0000;
        b_req_valid = 1'b0; b_req_wr = 1'b0; b_req_burst = 1'b0;
        b_req_addr = 8'h00; b_req_wdata = 16'h0000;
        repeat (3) step();
        vec_cnt++;
        if ({req_ready, rsp_valid, rsp_last, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            miss_cnt++;
            $display("FAIL reset: got rdy=%b v=%b l=%b d=%h, want 1 0 0 0000",
                     req_ready, rsp_valid, rsp_last, rsp_rdata);
        end
        vec_cnt++;
        if ({b_req_ready, b_rsp_valid, b_rsp_last, b_rsp_rdata} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            miss_cnt++;
            $display("FAIL reset_l1: got rdy=%b v=%b l=%b d=%h, want 1 0 0 0000",
                     b_req_ready, b_rsp_valid, b_rsp_last, b_rsp_rdata);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_preload();
        for (int w = 0; w < 64; w++) run_txn(1'b1, 1'b0, 16'(w * 2), 16'($urandom));
    endtask

    task automatic test_write_read();
        run_txn(1'b1, 1'b0, 16'h0010, 16'h1234);
        run_txn(1'b0, 1'b0, 16'h0010, 16'h0000);
        run_txn(1'b0, 1'b0, 16'h0011, 16'hFFFF);
    endtask

    task automatic test_burst();
        run_txn(1'b0, 1'b1, 16'h0026, 16'h0000);
        run_txn(1'b1, 1'b1, 16'h0030, 16'hCAFE);
        run_txn(1'b0, 1'b1, 16'h007F, 16'h0000);
    endtask

    task automatic test_back_to_back();
        run_txn(1'b0, 1'b0, 16'h0002, 16'h0000);
        run_txn(1'b1, 1'b0, 16'h0004, 16'h0F0F);
        run_txn(1'b0, 1'b1, 16'h0004, 16'h0000);
        run_txn(1'b0, 1'b0, 16'h0004, 16'h0000);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_txn(($urandom_range(0, 2) == 0), 1'($urandom),
                    16'($urandom_range(0, 127)), 16'($urandom));
        end
    endtask

    task automatic test_reset_abort();
        run_txn(1'b1, 1'b0, 16'h0040, 16'h5A5A);
        req_valid = 1'b1; req_wr = 1'b1; req_burst = 1'b0;
        req_addr = 16'h0040; req_wdata = 16'hBEEF;
        step();
        req_valid = 1'b0;
        vec_cnt++;
        if ({rsp_valid, req_ready} !== 2'b00) begin
            miss_cnt++;
            $display("FAIL abort_accept: got v=%b rdy=%b, want 0 0", rsp_valid, req_ready);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vec_cnt++;
        if ({req_ready, rsp_valid, rsp_last, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            miss_cnt++;
            $display("FAIL abort_idle: got rdy=%b v=%b l=%b d=%h, want 1 0 0 0000",
                     req_ready, rsp_valid, rsp_last, rsp_rdata);
        end
        for (int i = 0; i < 6; i++) begin
            vec_cnt++;
            if (rsp_valid !== 1'b0) begin
                miss_cnt++;
                $display("FAIL abort_quiet cyc=%0d: got v=%b, want 0", i, rsp_valid);
            end
            step();
        end
        run_txn(1'b0, 1'b0, 16'h0040, 16'h0000);
    endtask

    task automatic test_latency1();
        logic [15:0] bmodel [0:3];
        logic [7:0]  t_addr [4];
        bit          t_wr   [4];
        bit          t_bst  [4];
        logic [15:0] t_data [4];
        int n, wa, idx;
        logic [15:0] exp_d;
        bit exp_v, exp_l, exp_r;
        t_addr = '{8'h06, 8'h04, 8'h06, 8'h07};
        t_wr   = '{1'b1, 1'b1, 1'b0, 1'b0};
        t_bst  = '{1'b0, 1'b0, 1'b0, 1'b1};
        t_data = '{16'hA5C3, 16'h1111, 16'h0000, 16'h0000};
        for (int t = 0; t < 4; t++) begin
            vec_cnt++;
            if (b_req_ready !== 1'b1) begin
                miss_cnt++;
                $display("FAIL l1_ready op=%0d: got %b, want 1", t, b_req_ready);
            end
            b_req_valid = 1'b1; b_req_wr = t_wr[t]; b_req_burst = t_bst[t];
            b_req_addr = t_addr[t]; b_req_wdata = t_data[t];
            step();
            n  = (t_bst[t] && !t_wr[t]) ? 2 : 1;
            wa = int'(t_addr[t][7:1]);
            for (int k = 1; k <= n + 1; k++) begin
                b_req_valid = (k < n + 1);
                b_req_addr  = 8'($urandom);
                b_req_wr    = 1'($urandom);
                exp_v = (k <= n);
                exp_l = (k == n);
                exp_r = (k == n + 1);
                idx   = (n == 2) ? ((wa / 2) * 2 + (k - 1)) : wa;
                exp_d = (exp_v && !t_wr[t]) ? bmodel[idx - 2] : 16'h0000;
                vec_cnt++;
                if ({b_rsp_valid, b_rsp_last, b_req_ready, b_rsp_rdata} !== {exp_v, exp_l, exp_r, exp_d}) begin
                    miss_cnt++;
                    $display("FAIL l1 op=%0d cyc=%0d: got v=%b l=%b rdy=%b d=%h, want v=%b l=%b rdy=%b d=%h",
                             t, k, b_rsp_valid, b_rsp_last, b_req_ready, b_rsp_rdata,
                             exp_v, exp_l, exp_r, exp_d);
                end
                if (k < n + 1) step();
            end
            if (t_wr[t]) bmodel[wa - 2] = t_data[t];
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_write_read();
        test_burst();
        test_back_to_back();
        test_random();
        test_reset_abort();
        test_latency1();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
